// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface mc_controller_if;
    logic [6:0] op;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       retire;
    logic       illegal_op;

    modport master (
        input  op, branch_cond, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, retire, illegal_op
    );

    modport slave (
        output op, branch_cond, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, retire, illegal_op
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RISC-V style main controller: Moore FSM sequencing fetch,
// decode, memory, ALU, branch and jump steps, with a sticky trap on
// undecodable opcodes.
module mc_controller (
    input  logic           clk,
    input  logic           rst_n,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC, TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       pc_write;
        logic       illegal_op;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic state_t next_state(state_t s, logic [6:0] opc, logic ready);
        state_t n;
        n = s;
        case (s)
            FETCH:    if (ready) n = DECODE;
            DECODE: begin
                case (opc)
                    OP_LOAD, OP_STORE: n = MEMADR;
                    OP_R:              n = EXECR;
                    OP_I:              n = EXECI;
                    OP_BRANCH:         n = BRANCH;
                    OP_JAL:            n = JAL;
                    OP_JALR:           n = JALR;
                    OP_LUI:            n = LUI;
                    OP_AUIPC:          n = AUIPC;
                    default:           n = TRAP;
                endcase
            end
            MEMADR:   n = (opc == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (ready) n = MEMWB;
            MEMWB:    n = FETCH;
            MEMWRITE: if (ready) n = FETCH;
            EXECR:    n = ALUWB;
            EXECI:    n = ALUWB;
            ALUWB:    n = FETCH;
            BRANCH:   n = FETCH;
            JAL:      n = ALUWB;
            JALR:     n = LINK;
            LINK:     n = ALUWB;
            LUI:      n = ALUWB;
            AUIPC:    n = ALUWB;
            TRAP:     n = TRAP;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t moore_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.retire    = 1'b1;
            end
            JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            LINK: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            AUIPC: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            TRAP:    c.illegal_op = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state;
    ctrl_t      ctrl_q;
    logic [2:0] imm_sel;
    logic       fetch_done;

    // State register plus the Moore controls of the state being entered, so
    // both always describe the same state. Reset parks both on FETCH; the
    // rst_n gating below keeps every output at 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            ctrl_q <= moore_ctrl(FETCH);
        end else begin
            state  <= next_state(state, bus.op, bus.mem_ready);
            ctrl_q <= moore_ctrl(next_state(state, bus.op, bus.mem_ready));
        end
    end

    // Immediate type uses the live opcode: IR is loaded on the same edge that enters DECODE.
    always_comb begin
        imm_sel = 3'b000;
        case (state)
            DECODE:     imm_sel = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
            MEMADR:     imm_sel = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
            LUI, AUIPC: imm_sel = 3'b100;
            default:    imm_sel = 3'b000;
        endcase
    end

    assign fetch_done = (state == FETCH) && bus.mem_ready;

    assign bus.mem_req    = rst_n & ctrl_q.mem_req;
    assign bus.mem_write  = rst_n & ctrl_q.mem_write;
    assign bus.adr_src    = rst_n & ctrl_q.adr_src;
    assign bus.reg_write  = rst_n & ctrl_q.reg_write;
    assign bus.result_src = ctrl_q.result_src & {2{rst_n}};
    assign bus.alu_src_a  = ctrl_q.alu_src_a & {2{rst_n}};
    assign bus.alu_src_b  = ctrl_q.alu_src_b & {2{rst_n}};
    assign bus.alu_op     = ctrl_q.alu_op & {2{rst_n}};
    assign bus.imm_src    = imm_sel & {3{rst_n}};
    assign bus.illegal_op = rst_n & ctrl_q.illegal_op;
    assign bus.ir_write   = rst_n & fetch_done;
    assign bus.pc_write   = rst_n & (ctrl_q.pc_write | fetch_done |
                                     ((state == BRANCH) & bus.branch_cond));
    assign bus.retire     = rst_n & (ctrl_q.retire |
                                     ((state == MEMWRITE) & bus.mem_ready));
endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: each instruction is
// checked against per-instruction expectations derived from its class.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned total = 0;
    int unsigned bad = 0;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_t kind_of(logic [6:0] o);
        case (o)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            default:    return K_AUIPC;
        endcase
    endfunction

    function automatic logic [18:0] all_out();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.imm_src, bus.retire, bus.illegal_op};
    endfunction

    task automatic tick(input logic rdy);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
    endtask

    // Runs one instruction from its first FETCH cycle until retire.
    // wf / wm: wait cycles inserted on the fetch and data accesses.
    task automatic run_instr(input logic [6:0] opc, input logic bc,
                             input int unsigned wf, input int unsigned wm);
        kind_t k;
        int unsigned n, acc, waits, regw, pcw, memw, memreq, irw, ret;
        int unsigned exp_cycles, exp_regw, exp_pcw, exp_memw, exp_memreq;
        bit in_acc, done;
        logic acc_adr, acc_wr;
        logic [1:0] exp_res;
        logic [8:0] exp_exec;
        k = kind_of(opc);
        bus.op = opc;
        bus.branch_cond = bc;
        n = 0; acc = 0; waits = 0; regw = 0; pcw = 0; memw = 0; memreq = 0;
        irw = 0; ret = 0; in_acc = 0; done = 0; acc_adr = 0; acc_wr = 0;

        case (k)
            K_LOAD:  exp_cycles = wf + 2 + 3 + wm;
            K_STORE: exp_cycles = wf + 2 + 2 + wm;
            K_BR:    exp_cycles = wf + 2 + 1;
            K_JALR:  exp_cycles = wf + 2 + 3;
            default: exp_cycles = wf + 2 + 2;
        endcase
        exp_regw   = (k == K_STORE || k == K_BR) ? 0 : 1;
        exp_pcw    = 1 + ((k == K_BR) ? int'(bc) : (k == K_JAL || k == K_JALR) ? 1 : 0);
        exp_memw   = (k == K_STORE) ? 1 + wm : 0;
        exp_memreq = 1 + wf + ((k == K_LOAD || k == K_STORE) ? 1 + wm : 0);
        exp_res    = (k == K_LOAD) ? 2'b01 : 2'b00;
        // {alu_src_a, alu_src_b, alu_op, imm_src} in the step after decode
        case (k)
            K_LOAD:  exp_exec = {2'b10, 2'b01, 2'b00, 3'b000};
            K_STORE: exp_exec = {2'b10, 2'b01, 2'b00, 3'b001};
            K_R:     exp_exec = {2'b10, 2'b00, 2'b10, 3'b000};
            K_I:     exp_exec = {2'b10, 2'b01, 2'b10, 3'b000};
            K_BR:    exp_exec = {2'b10, 2'b00, 2'b01, 3'b000};
            K_JAL:   exp_exec = {2'b01, 2'b10, 2'b00, 3'b000};
            K_JALR:  exp_exec = {2'b10, 2'b01, 2'b00, 3'b000};
            K_LUI:   exp_exec = {2'b11, 2'b01, 2'b00, 3'b100};
            default: exp_exec = {2'b01, 2'b01, 2'b00, 3'b100};
        endcase

        while (!done && n < 60) begin
            @(negedge clk);
            #1;
            if (bus.mem_req) begin
                if (!in_acc) begin
                    in_acc = 1;
                    acc++;
                    waits = (acc == 1) ? wf : wm;
                    acc_adr = bus.adr_src;
                    acc_wr = bus.mem_write;
                end else begin
                    chk("acc_adr_stable", bus.adr_src, acc_adr);
                    chk("acc_wr_stable", bus.mem_write, acc_wr);
                end
                bus.mem_ready = (waits == 0);
                if (waits > 0) waits--;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n++;
            regw   += bus.reg_write;
            pcw    += bus.pc_write;
            memw   += bus.mem_write;
            memreq += bus.mem_req;
            irw    += bus.ir_write;
            chk("one_strobe", (int'(bus.pc_write) + int'(bus.reg_write) + int'(bus.mem_write)) <= 1, 1);
            chk("no_illegal", bus.illegal_op, 0);
            if (n <= wf + 1)
                chk("fetch_ctl", {bus.mem_req, bus.adr_src, bus.mem_write, bus.alu_src_a,
                                  bus.alu_src_b, bus.alu_op, bus.result_src, bus.reg_write, bus.retire},
                    {1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0});
            if (n == wf + 2)
                chk("decode_ctl", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src},
                    {2'b01, 2'b01, 2'b00, (k == K_JAL) ? 3'b011 : 3'b010});
            if (n == wf + 3)
                chk("exec_ctl", {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src}, exp_exec);
            if (k == K_JALR && n == wf + 4)
                chk("link_ctl", {bus.alu_src_a, bus.alu_src_b}, {2'b01, 2'b10});
            if (bus.reg_write) chk("wb_result_src", bus.result_src, exp_res);
            if (bus.mem_req && bus.mem_ready) in_acc = 0;
            if (bus.retire) begin
                ret++;
                done = 1;
            end
        end
        chk("retired", done, 1);
        chk("cycles", n, exp_cycles);
        chk("reg_write_cnt", regw, exp_regw);
        chk("pc_write_cnt", pcw, exp_pcw);
        chk("mem_write_cnt", memw, exp_memw);
        chk("mem_req_cnt", memreq, exp_memreq);
        chk("ir_write_cnt", irw, 1);
    endtask

    logic [6:0] legal [9];

    initial begin
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rst_n = 1'b0;
        bus.op = 7'b0110011;
        bus.branch_cond = 1'b1;
        bus.mem_ready = 1'b1;
        #12;
        chk("reset_outputs", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("post_reset_fetch", {bus.mem_req, bus.adr_src, bus.illegal_op}, 3'b100);

        // directed cases
        run_instr(7'b0110011, 1'b0, 0, 0);   // R-type add
        run_instr(7'b0000011, 1'b0, 0, 3);   // load, 3 wait cycles
        run_instr(7'b1100011, 1'b0, 0, 0);   // beq not taken
        run_instr(7'b1100011, 1'b1, 0, 0);   // beq taken
        run_instr(7'b1100111, 1'b0, 0, 0);   // jalr
        run_instr(7'b1101111, 1'b0, 1, 0);   // jal, fetch wait
        run_instr(7'b0100011, 1'b0, 2, 2);   // store with waits

        // randomized instruction stream
        for (int i = 0; i < 40; i++)
            run_instr(legal[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        // undecodable opcode traps until reset
        bus.op = 7'b1111111;
        tick(1'b1);
        tick(1'b0);
        chk("decode_before_trap", bus.illegal_op, 0);
        for (int i = 0; i < 10; i++) begin
            bus.branch_cond = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)));
            chk("trap_flag", bus.illegal_op, 1);
            chk("trap_strobes", {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write,
                                 bus.reg_write, bus.retire}, 0);
        end
        #1;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("trap_reset_outputs", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("trap_release_fetch", {bus.illegal_op, bus.mem_req, bus.adr_src, bus.mem_write}, 4'b0100);
        run_instr(7'b0010011, 1'b0, 0, 0);

        // reset in the middle of a store access
        bus.op = 7'b0100011;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("store_access", {bus.mem_req, bus.mem_write, bus.adr_src}, 3'b111);
        tick(1'b0);
        #1;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("abort_outputs", all_out(), 0);
        @(posedge clk);
        #1;
        chk("abort_no_retire", {bus.retire, bus.mem_req, bus.mem_write}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        chk("abort_release_fetch", {bus.mem_req, bus.mem_write, bus.adr_src, bus.retire}, 4'b1000);
        run_instr(7'b0110111, 1'b0, 0, 0);
        run_instr(7'b0100011, 1'b0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
